// File: rtl/xs3_to_bcd_deser.sv
// Serial Excess-3 to packed-BCD decoder: one digit per handshake in, one
// NUM_DIGITS-digit BCD word per handshake out, first digit in the MS nibble.
// Valid/ready: a transfer happens on a rising edge where valid and ready are
// both 1; a source holds its data stable while valid=1 and ready=0.
module xs3_to_bcd_deser #(
  parameter int NUM_DIGITS = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_xs3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_bcd,
  output logic [NUM_DIGITS-1:0]   out_err_mask,
  output logic                    out_err,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [W-1:0]          sr;
  logic [W-1:0]          next_sr;
  logic [W-1:0]          nib_w;
  logic [NUM_DIGITS-1:0] mask_sr;
  logic [NUM_DIGITS-1:0] next_mask;
  logic [NUM_DIGITS-1:0] bad_w;
  logic [3:0]            nib;
  logic                  bad;
  logic                  accept;
  logic                  last;

  // Codes outside 3..12 are not Excess-3; they are stored as 4'hF.
  always_comb begin
    bad       = (in_xs3 < 4'd3) || (in_xs3 > 4'd12);
    nib       = bad ? 4'hF : (in_xs3 - 4'd3);
    nib_w     = '0;
    nib_w[3:0] = nib;
    bad_w     = '0;
    bad_w[0]  = bad;
    next_sr   = (sr << 4) | nib_w;
    next_mask = (mask_sr << 1) | bad_w;
  end

  // In HOLD the input is only open when the word leaves this same cycle.
  assign in_ready = rst_n & ((state == COLLECT) | out_ready);
  assign accept   = in_valid & in_ready;
  assign last     = (cnt == CNT_W'(NUM_DIGITS - 1));
  assign out_err  = |out_err_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= COLLECT;
      cnt          <= '0;
      sr           <= '0;
      mask_sr      <= '0;
      out_valid    <= 1'b0;
      out_bcd      <= '0;
      out_err_mask <= '0;
      err_count    <= '0;
    end else begin
      if (accept && bad && (err_count != '1))
        err_count <= err_count + 1'b1;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (last) begin
              out_bcd      <= next_sr;
              out_err_mask <= next_mask;
              out_valid    <= 1'b1;
              cnt          <= '0;
              state        <= HOLD;
            end else begin
              sr      <= next_sr;
              mask_sr <= next_mask;
              cnt     <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (accept && (NUM_DIGITS == 1)) begin
              out_bcd      <= next_sr;
              out_err_mask <= next_mask;
            end else if (accept) begin
              // The digit accepted alongside the handoff opens the next word.
              sr        <= next_sr;
              mask_sr   <= next_mask;
              cnt       <= CNT_W'(1);
              out_valid <= 1'b0;
              state     <= COLLECT;
            end else begin
              out_valid <= 1'b0;
              state     <= COLLECT;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
